// File: rtl/mul_div_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The master drives the request side; the slave (the unit) drives Busy/Done/MDResult.
interface mul_div_if #(
   parameter int D_WIDTH = 32
);
   logic               Start;
   logic [2:0]         MDControl;
   logic [D_WIDTH-1:0] SrcA;
   logic [D_WIDTH-1:0] SrcB;
   logic               Busy;
   logic               Done;
   logic [D_WIDTH-1:0] MDResult;

   modport master (
      output Start, MDControl, SrcA, SrcB,
      input  Busy, Done, MDResult
   );

   modport slave (
      input  Start, MDControl, SrcA, SrcB,
      output Busy, Done, MDResult
   );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude wrapper around an unsigned
// shift-add multiplier and restoring divider, one step per cycle.
module mul_div_unit #(
   parameter int D_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   mul_div_if.slave   md,
   output logic [1:0] o_dbg_state
);
   localparam int CW = $clog2(D_WIDTH);
   localparam logic [D_WIDTH-1:0] MINV = {1'b1, {(D_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [2:0]         r_ctl;
   logic [D_WIDTH-1:0] r_hi, r_lo, r_op, r_result;
   logic               r_neg_p, r_neg_r, r_busy, r_done;

   // Capture-side decode on the live request inputs
   logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
   logic [D_WIDTH-1:0] w_a_mag, w_b_mag, w_special_res;
   logic               w_div0, w_ovf, w_special, w_accept;

   assign w_a_signed = md.MDControl[2] ? ~md.MDControl[0] : (md.MDControl[1:0] != 2'b11);
   assign w_b_signed = md.MDControl[2] ? ~md.MDControl[0] : ~md.MDControl[1];
   assign w_a_neg    = w_a_signed & md.SrcA[D_WIDTH-1];
   assign w_b_neg    = w_b_signed & md.SrcB[D_WIDTH-1];
   assign w_a_mag    = w_a_neg ? -md.SrcA : md.SrcA;
   assign w_b_mag    = w_b_neg ? -md.SrcB : md.SrcB;
   assign w_div0     = md.MDControl[2] & (md.SrcB == '0);
   assign w_ovf      = md.MDControl[2] & ~md.MDControl[0] &
                       (md.SrcA == MINV) & (md.SrcB == '1);
   assign w_special  = w_div0 | w_ovf;
   assign w_special_res = w_div0 ? (md.MDControl[1] ? md.SrcA : '1)
                                 : (md.MDControl[1] ? '0 : MINV);
   assign w_accept   = md.Start & (r_state != S_CALC);

   // One iteration: r_hi = accumulator / partial remainder, r_lo = multiplier / quotient
   logic [D_WIDTH:0]     w_mul_sum, w_trial;
   logic                 w_ge;
   logic [D_WIDTH-1:0]   w_nhi, w_nlo, w_quo, w_rem, w_final;
   logic [2*D_WIDTH-1:0] w_prod, w_prod_s;

   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
   assign w_trial   = {r_hi, r_lo[D_WIDTH-1]} - {1'b0, r_op};
   assign w_ge      = ~w_trial[D_WIDTH];
   assign w_nhi = r_ctl[2] ? (w_ge ? w_trial[D_WIDTH-1:0] : {r_hi[D_WIDTH-2:0], r_lo[D_WIDTH-1]})
                           : w_mul_sum[D_WIDTH:1];
   assign w_nlo = r_ctl[2] ? {r_lo[D_WIDTH-2:0], w_ge}
                           : {w_mul_sum[0], r_lo[D_WIDTH-1:1]};

   assign w_prod   = {w_nhi, w_nlo};
   assign w_prod_s = r_neg_p ? -w_prod : w_prod;
   assign w_quo    = r_neg_p ? -w_nlo : w_nlo;
   assign w_rem    = r_neg_r ? -w_nhi : w_nhi;
   assign w_final  = r_ctl[2] ? (r_ctl[1] ? w_rem : w_quo)
                              : ((r_ctl[1:0] == 2'b00) ? w_prod_s[D_WIDTH-1:0]
                                                       : w_prod_s[2*D_WIDTH-1:D_WIDTH]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_ctl    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_neg_p  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_CALC: begin
               r_hi  <= w_nhi;
               r_lo  <= w_nlo;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(D_WIDTH-1)) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_result <= w_final;
               end
            end
            default: begin
               if (w_accept) begin
                  r_ctl   <= md.MDControl;
                  r_hi    <= '0;
                  r_lo    <= md.MDControl[2] ? w_a_mag : w_b_mag;
                  r_op    <= md.MDControl[2] ? w_b_mag : w_a_mag;
                  r_neg_p <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_cnt   <= '0;
                  if (w_special) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_result <= w_special_res;
                  end else begin
                     r_state <= S_CALC;
                     r_busy  <= 1'b1;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign md.Busy     = r_busy;
   assign md.Done     = r_done;
   assign md.MDResult = r_result;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV32M vectors plus randomized ops against
// an arithmetic reference model; checks results, latency and Busy/Done timing.
module tb_mul_div_unit;
   localparam int W = 32;
   localparam logic [W-1:0] MINV = 32'h8000_0000;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   mul_div_if #(.D_WIDTH(W)) md_bus ();

   mul_div_unit #(.D_WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .md          (md_bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_md(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      longint sa, sb, ub, p;
      logic [63:0] pu;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = a;
      ib = b;
      pu = {32'b0, a} * {32'b0, b};
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: return pu[63:32];
         3'd4: begin
            if (b == 0) return '1;
            if (a == MINV && b == '1) return MINV;
            return ia / ib;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MINV && b == '1) return '0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit ref_special(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      return op[2] && ((b == 0) || (!op[0] && a == MINV && b == '1));
   endfunction

   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      md_bus.Start     = 1'b1;
      md_bus.MDControl = op;
      md_bus.SrcA      = a;
      md_bus.SrcB      = b;
   endtask

   // Called at the first negedge after the capture edge; returns at the negedge where Done is seen.
   task automatic measure(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int disturb_at);
      int edge_n, busy_n, overlap;
      bit seen, special;
      exp_q.push_back(ref_md(op, a, b));
      special = ref_special(op, a, b);
      edge_n = 1; busy_n = 0; overlap = 0; seen = 0;
      md_bus.Start = 1'b0;
      md_bus.SrcA  = $urandom();
      md_bus.SrcB  = $urandom();
      while (!seen && edge_n <= 40) begin
         if (md_bus.Busy && md_bus.Done) overlap++;
         if (md_bus.Done) seen = 1'b1;
         else begin
            if (md_bus.Busy) busy_n++;
            if (edge_n == disturb_at) drive(3'($urandom_range(0, 7)), $urandom(), $urandom());
            else md_bus.Start = 1'b0;
            @(negedge clk);
            edge_n++;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(edge_n), special ? 32'd1 : 32'd33);
      check({tag, "_busy_cycles"}, 32'(busy_n), special ? 32'd0 : 32'd32);
      check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
      check({tag, "_result"}, md_bus.MDResult, exp_q.pop_front());
   endtask

   task automatic hold_check(input string tag, input logic [W-1:0] exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(md_bus.Done), 32'd0);
      check({tag, "_hold"}, md_bus.MDResult, exp);
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int disturb_at);
      @(negedge clk);
      drive(op, a, b);
      @(negedge clk);
      measure(tag, op, a, b, disturb_at);
      hold_check(tag, ref_md(op, a, b));
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      int           dones;

      rst = 1'b1;
      md_bus.Start = 1'b0; md_bus.MDControl = '0; md_bus.SrcA = '0; md_bus.SrcB = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(md_bus.Busy), 32'd0);
      check("reset_done", 32'(md_bus.Done), 32'd0);
      check("reset_result", md_bus.MDResult, 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
      run_op("mulh_min", 3'd1, MINV, MINV, 0);
      run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
      run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
      run_op("divu_by0", 3'd5, 32'h1234_5678, 32'd0, 0);
      run_op("rem_5_by0", 3'd6, 32'd5, 32'd0, 0);
      run_op("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 0);
      run_op("div_by0", 3'd4, 32'hDEAD_BEEF, 32'd0, 0);

      // Start pulsed mid-CALC must be ignored
      run_op("start_mid_calc", 3'd4, 32'hFFFF_0001, 32'd13, 10);

      // Back-to-back: second Start presented in the Done cycle
      @(negedge clk);
      drive(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      @(negedge clk);
      measure("b2b_first", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      drive(3'd7, 32'hFFFF_FFFF, 32'd10);
      @(negedge clk);
      measure("b2b_second", 3'd7, 32'hFFFF_FFFF, 32'd10, 0);
      hold_check("b2b_second", ref_md(3'd7, 32'hFFFF_FFFF, 32'd10));

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom();
         case ($urandom_range(0, 9))
            0:       b = '0;
            1:       begin a = MINV; b = '1; end
            2:       b = 32'($urandom_range(1, 15));
            default: b = $urandom();
         endcase
         run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 0);
      end

      // Reset partway through a DIV aborts it with no Done
      @(negedge clk);
      drive(3'd4, 32'h7654_3210, 32'd3);
      @(negedge clk);
      md_bus.Start = 1'b0;
      dones = 0;
      repeat (9) begin
         if (md_bus.Done) dones++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", 32'(md_bus.Busy), 32'd0);
      check("rst_mid_result", md_bus.MDResult, 32'd0);
      check("rst_mid_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      repeat (40) begin
         if (md_bus.Done) dones++;
         @(negedge clk);
      end
      check("rst_mid_no_done", 32'(dones), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
